// File: rtl/ip_tx_arbiter_pkg.sv
// Shared widths, request record and FSM encoding for the ip_packet_tx arbiter.
package ip_tx_pkg;

    localparam int IP_ADDR_W  = 32;
    localparam int MAC_ADDR_W = 48;
    localparam int MSG_W      = 10;

    typedef struct packed {
        logic [IP_ADDR_W-1:0]  ip;
        logic [MAC_ADDR_W-1:0] mac;
        logic [MSG_W-1:0]      message;
    } ip_tx_req_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } ip_tx_arb_state_e;

endpackage

// File: rtl/ip_tx_arbiter_if.sv
// Requester bundle plus ip_packet_tx accelerator-side ports. The arbiter is the
// master; the requesters and the transmitter together form the slave side.
interface ip_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import ip_tx_pkg::*;

    localparam int GRANT_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic [NUM_REQ*IP_ADDR_W-1:0]  REQ_IP_ADDRESS;
    logic [NUM_REQ*MAC_ADDR_W-1:0] REQ_MAC_ADDRESS;
    logic [NUM_REQ*MSG_W-1:0]      REQ_MESSAGE;
    logic [NUM_REQ-1:0]            REQ_DONE;

    logic [IP_ADDR_W-1:0]          RECIPIENT_IP_ADDRESS;
    logic [MAC_ADDR_W-1:0]         RECIPIENT_MAC_ADDRESS;
    logic [MSG_W-1:0]              RECIPIENT_MESSAGE;
    logic                          START_IP_TXN;
    logic                          READY_FOR_SEND;

    logic [GRANT_W-1:0]            GRANT_ID;
    logic                          BUSY;
    logic                          START_RETRY;

    modport master (
        input  REQ_VALID, REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE, READY_FOR_SEND,
        output REQ_READY, REQ_DONE, RECIPIENT_IP_ADDRESS, RECIPIENT_MAC_ADDRESS,
               RECIPIENT_MESSAGE, START_IP_TXN, GRANT_ID, BUSY, START_RETRY
    );

    modport slave (
        output REQ_VALID, REQ_IP_ADDRESS, REQ_MAC_ADDRESS, REQ_MESSAGE, READY_FOR_SEND,
        input  REQ_READY, REQ_DONE, RECIPIENT_IP_ADDRESS, RECIPIENT_MAC_ADDRESS,
               RECIPIENT_MESSAGE, START_IP_TXN, GRANT_ID, BUSY, START_RETRY
    );

endinterface

// File: rtl/ip_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request searching upward from
// last_grant+1 with wrap-around.
module rr_priority_select #(
    parameter  int N = 2,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        // Offset N lands back on last_grant itself, so a lone requester can win again.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant_idx  = W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing one ip_packet_tx between NUM_REQ requesters:
// latches the winner's packet, sequences the start handshake, reports completion.
module ip_tx_arbiter
    import ip_tx_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic            ACLK,
    input  logic            ARESET,
    ip_tx_arbiter_if.master bus
);

    localparam int GRANT_W = $clog2(NUM_REQ);
    localparam logic [15:0] TIMEOUT_CNT = 16'(START_TIMEOUT);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    ip_tx_arb_state_e   state_reg, state_next;
    logic [15:0]        cnt_reg, cnt_inc;
    logic [GRANT_W-1:0] grant_id_reg, last_grant_reg;
    ip_tx_req_t         cap_reg;
    logic               start_reg, retry_reg;
    logic [NUM_REQ-1:0] done_reg;

    ip_tx_req_t         req_data [NUM_REQ];
    logic [NUM_REQ-1:0] grant_oh;
    logic [GRANT_W-1:0] grant_idx;
    logic               any_grant, arb_en, accept, timeout_hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_data[gi] = {bus.REQ_IP_ADDRESS[gi*IP_ADDR_W +: IP_ADDR_W],
                               bus.REQ_MAC_ADDRESS[gi*MAC_ADDR_W +: MAC_ADDR_W],
                               bus.REQ_MESSAGE[gi*MSG_W +: MSG_W]};
    end

    rr_priority_select #(.N(NUM_REQ)) u_rr (
        .req        (bus.REQ_VALID),
        .last_grant (last_grant_reg),
        .grant      (grant_oh),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    // The REQ_DONE cycle is held off arbitration so a new grant lands one cycle later.
    assign arb_en      = (state_reg == ST_IDLE) && bus.READY_FOR_SEND && !(|done_reg);
    assign accept      = arb_en && any_grant;
    assign cnt_inc     = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (accept) state_next = ST_START;
            ST_START:     state_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!bus.READY_FOR_SEND)  state_next = ST_WAIT_DONE;
                else if (timeout_hit)     state_next = ST_START;
            end
            ST_WAIT_DONE: if (bus.READY_FOR_SEND) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            grant_id_reg   <= '0;
            last_grant_reg <= GRANT_W'(NUM_REQ - 1);
            cap_reg        <= '0;
            start_reg      <= 1'b0;
            retry_reg      <= 1'b0;
            done_reg       <= '0;
        end else begin
            state_reg <= state_next;
            start_reg <= (state_next == ST_START);
            retry_reg <= (state_reg == ST_WAIT_BUSY) && bus.READY_FOR_SEND && timeout_hit;
            done_reg  <= ((state_reg == ST_WAIT_DONE) && bus.READY_FOR_SEND)
                         ? (ONE_HOT_0 << grant_id_reg) : '0;

            if (state_reg == ST_START)
                cnt_reg <= '0;
            else if ((state_reg == ST_WAIT_BUSY) && bus.READY_FOR_SEND)
                cnt_reg <= cnt_inc;

            if (accept) begin
                cap_reg        <= req_data[grant_idx];
                grant_id_reg   <= grant_idx;
                last_grant_reg <= grant_idx;
            end
        end
    end

    assign bus.REQ_READY             = arb_en ? grant_oh : '0;
    assign bus.REQ_DONE              = done_reg;
    assign bus.RECIPIENT_IP_ADDRESS  = cap_reg.ip;
    assign bus.RECIPIENT_MAC_ADDRESS = cap_reg.mac;
    assign bus.RECIPIENT_MESSAGE     = cap_reg.message;
    assign bus.START_IP_TXN          = start_reg;
    assign bus.GRANT_ID              = grant_id_reg;
    assign bus.BUSY                  = (state_reg != ST_IDLE);
    assign bus.START_RETRY           = retry_reg;

endmodule
